coord_gen: RTL and testbench

COORD_GEN -- requirements
Module: coord_gen

---
 rtl/coord_gen_pkg.sv | 28 ++
 rtl/coord_gen.sv | 190 +++++++++++++++++++
 tb/tb_coord_gen.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coord_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : coord_gen_pkg
//  Description : Shared interpolation constants and types. Holds the
//                coordinate width, the default block pitch and the raster
//                coordinate generator state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package coord_gen_pkg;

    // Width of a signed pixel coordinate (two's complement).
    localparam int COORD_W      = 8;

    // Default pixel pitch between adjacent blocks.
    localparam int STEP_DEFAULT = 8;

    typedef logic signed [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_FINISH  = 3'd4
    } cg_state_e;

endpackage : coord_gen_pkg
`default_nettype wire

// File: rtl/coord_gen.sv
`default_nettype none
// ============================================================================
//  Module      : coord_gen
//  Description : Raster-order block coordinate generator. On START it
//                captures the upper-left base coordinate and the block grid
//                size, then walks the grid row-major, presenting each block's
//                (x, y) with a one-cycle WRITE_EN and waiting for BLOCK_DONE
//                before moving on. DONE pulses once the scan completes (or
//                immediately for an empty grid).
//
//  Ports       : CLK          - clock, rising edge active
//                RST_ASYNC_N  - asynchronous active-low reset
//                START        - scan request, honoured only when idle
//                BASE_X/Y     - signed upper-left coordinate of first block
//                NUM_COLS/ROWS- grid size in blocks
//                BLOCK_DONE   - downstream finished current block
//                COORD_X/Y    - current block coordinate
//                WRITE_EN     - load strobe for the coordinate registers
//                BUSY         - high whenever not idle
//                DONE         - one-cycle scan-complete pulse
//
//  Revision    : 1.0 - initial release
// ============================================================================
module coord_gen
    import coord_gen_pkg::*;
#(
    parameter int STEP  = STEP_DEFAULT,
    parameter int CNT_W = 4
) (
    input  logic                      CLK,
    input  logic                      RST_ASYNC_N,
    input  logic                      START,
    input  logic signed [COORD_W-1:0] BASE_X,
    input  logic signed [COORD_W-1:0] BASE_Y,
    input  logic        [CNT_W-1:0]   NUM_COLS,
    input  logic        [CNT_W-1:0]   NUM_ROWS,
    input  logic                      BLOCK_DONE,
    output logic signed [COORD_W-1:0] COORD_X,
    output logic signed [COORD_W-1:0] COORD_Y,
    output logic                      WRITE_EN,
    output logic                      BUSY,
    output logic                      DONE
);

    // Pitch truncated to coordinate width; additions then wrap modulo 2^8.
    localparam coord_t STEP_C = coord_t'(STEP);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    cg_state_e          state_q,    state_d;
    coord_t             base_x_q,   base_x_d;
    logic [CNT_W-1:0]   num_cols_q, num_cols_d;
    logic [CNT_W-1:0]   num_rows_q, num_rows_d;
    logic [CNT_W-1:0]   col_q,      col_d;
    logic [CNT_W-1:0]   row_q,      row_d;
    coord_t             coord_x_q,  coord_x_d;
    coord_t             coord_y_q,  coord_y_d;
    logic               write_en_q, write_en_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;

    logic               last_col;
    logic               last_row;
    logic               empty_grid;

    // Counters are only compared while a non-empty scan is running, so the
    // "minus one" never underflows in a way that matters.
    assign last_col   = (col_q == (num_cols_q - CNT_W'(1)));
    assign last_row   = (row_q == (num_rows_q - CNT_W'(1)));
    assign empty_grid = (NUM_COLS == '0) || (NUM_ROWS == '0);

    // ------------------------------------------------------------------------
    // Process 1: state and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            state_q    <= ST_IDLE;
            base_x_q   <= '0;
            num_cols_q <= '0;
            num_rows_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            coord_x_q  <= '0;
            coord_y_q  <= '0;
            write_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_x_q   <= base_x_d;
            num_cols_q <= num_cols_d;
            num_rows_q <= num_rows_d;
            col_q      <= col_d;
            row_q      <= row_d;
            coord_x_q  <= coord_x_d;
            coord_y_q  <= coord_y_d;
            write_en_q <= write_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Process 2: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = empty_grid ? ST_FINISH : ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (BLOCK_DONE) begin
                    state_d = (last_col && last_row) ? ST_FINISH : ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                state_d = ST_LOAD;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Process 3: output and datapath next values
    // Strobes are derived from the next state so that they are registered
    // yet line up exactly with the state they describe.
    // ------------------------------------------------------------------------
    always_comb begin
        base_x_d   = base_x_q;
        num_cols_d = num_cols_q;
        num_rows_d = num_rows_q;
        col_d      = col_q;
        row_d      = row_q;
        coord_x_d  = coord_x_q;
        coord_y_d  = coord_y_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    base_x_d   = BASE_X;
                    num_cols_d = NUM_COLS;
                    num_rows_d = NUM_ROWS;
                    col_d      = '0;
                    row_d      = '0;
                    coord_x_d  = BASE_X;
                    coord_y_d  = BASE_Y;
                end
            end
            ST_ADVANCE: begin
                if (!last_col) begin
                    col_d     = col_q + CNT_W'(1);
                    coord_x_d = coord_x_q + STEP_C;
                end else begin
                    // Wrap to the start of the next row.
                    col_d     = '0;
                    row_d     = row_q + CNT_W'(1);
                    coord_x_d = base_x_q;
                    coord_y_d = coord_y_q + STEP_C;
                end
            end
            default: begin
                // LOAD, WAIT and FINISH hold the datapath.
            end
        endcase

        write_en_d = (state_d == ST_LOAD);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_FINISH);
    end

    assign COORD_X  = coord_x_q;
    assign COORD_Y  = coord_y_q;
    assign WRITE_EN = write_en_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

endmodule : coord_gen
`default_nettype wire

// File: tb/tb_coord_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coord_gen
//  Description : Self-checking bench for coord_gen. A reference model lists
//                the expected raster coordinates with plain nested loops and
//                modulo-256 arithmetic; a driver answers WRITE_EN with
//                BLOCK_DONE after a programmable delay and records what the
//                design produced.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coord_gen;

    localparam int STEP  = 8;
    localparam int CNT_W = 4;

    logic                    CLK         = 1'b0;
    logic                    RST_ASYNC_N = 1'b0;
    logic                    START       = 1'b0;
    logic                    BLOCK_DONE  = 1'b0;
    logic signed [7:0]       BASE_X      = '0;
    logic signed [7:0]       BASE_Y      = '0;
    logic [CNT_W-1:0]        NUM_COLS    = '0;
    logic [CNT_W-1:0]        NUM_ROWS    = '0;
    logic signed [7:0]       COORD_X;
    logic signed [7:0]       COORD_Y;
    logic                    WRITE_EN;
    logic                    BUSY;
    logic                    DONE;

    int n_checks = 0;
    int n_fail   = 0;

    coord_gen #(
        .STEP  (STEP),
        .CNT_W (CNT_W)
    ) u_dut (
        .CLK         (CLK),
        .RST_ASYNC_N (RST_ASYNC_N),
        .START       (START),
        .BASE_X      (BASE_X),
        .BASE_Y      (BASE_Y),
        .NUM_COLS    (NUM_COLS),
        .NUM_ROWS    (NUM_ROWS),
        .BLOCK_DONE  (BLOCK_DONE),
        .COORD_X     (COORD_X),
        .COORD_Y     (COORD_Y),
        .WRITE_EN    (WRITE_EN),
        .BUSY        (BUSY),
        .DONE        (DONE)
    );

    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------------
    // Observation record of the most recent scan
    // ------------------------------------------------------------------------
    logic signed [7:0] obs_x[$];
    logic signed [7:0] obs_y[$];
    int                we_cyc[$];
    int                done_cnt;
    int                done_cyc;
    int                busy_cyc;
    int                double_we;
    bit                busy_end;
    bit                timed_out;

    // Expected coordinates from the reference model
    logic signed [7:0] exp_x[$];
    logic signed [7:0] exp_y[$];

    // Raster order: row-major, each coordinate is base + index*STEP mod 256.
    task automatic build_expected(input logic signed [7:0] bx, input logic signed [7:0] by,
                                  input int nc, input int nr);
        exp_x.delete();
        exp_y.delete();
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < nc; c++) begin
                exp_x.push_back(8'(int'(bx) + c * STEP));
                exp_y.push_back(8'(int'(by) + r * STEP));
            end
        end
    endtask

    // mode bit0: pulse START during the scan; bit1: change BASE/NUM after capture.
    // dly < 0 holds BLOCK_DONE high throughout.
    task automatic run_scan(input logic signed [7:0] bx, input logic signed [7:0] by,
                            input int nc, input int nr, input int dly, input int mode);
        int cyc;
        int post;
        int pend;
        bit prev_we;
        obs_x.delete();
        obs_y.delete();
        we_cyc.delete();
        done_cnt  = 0;
        done_cyc  = -1;
        busy_cyc  = 0;
        double_we = 0;
        timed_out = 0;
        BASE_X     = bx;
        BASE_Y     = by;
        NUM_COLS   = CNT_W'(nc);
        NUM_ROWS   = CNT_W'(nr);
        START      = 1'b1;
        BLOCK_DONE = (dly < 0);
        @(posedge CLK); #1;
        START = 1'b0;
        if (mode[1]) begin
            BASE_X   = bx ^ 8'h5A;
            BASE_Y   = by ^ 8'h33;
            NUM_COLS = CNT_W'(nc + 2);
            NUM_ROWS = CNT_W'(nr + 1);
        end
        cyc     = 0;
        post    = 0;
        pend    = -1;
        prev_we = 1'b0;
        while (post < 4) begin
            if (cyc >= 800) begin
                timed_out = 1'b1;
                break;
            end
            if (WRITE_EN) begin
                obs_x.push_back(COORD_X);
                obs_y.push_back(COORD_Y);
                we_cyc.push_back(cyc);
                if (prev_we) double_we++;
                pend = dly;
            end
            prev_we = WRITE_EN;
            if (BUSY) busy_cyc++;
            if (DONE) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cnt > 0) post++;
            if (dly < 0) begin
                BLOCK_DONE = 1'b1;
            end else if (pend == 0) begin
                BLOCK_DONE = 1'b1;
                pend = -1;
            end else begin
                BLOCK_DONE = 1'b0;
                if (pend > 0) pend--;
            end
            START = mode[0] && (cyc == 3);
            @(posedge CLK); #1;
            cyc++;
        end
        busy_end   = BUSY;
        BLOCK_DONE = 1'b0;
        START      = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        int bad;
        #12;
        n_checks++;
        if ({COORD_X, COORD_Y, WRITE_EN, BUSY, DONE} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_state: x=%0d y=%0d we=%b busy=%b done=%b, required all 0",
                     COORD_X, COORD_Y, WRITE_EN, BUSY, DONE);
        end
        @(negedge CLK);
        RST_ASYNC_N = 1'b1;
        // Launch a scan, then reset during its LOAD cycle.
        @(posedge CLK); #1;
        BASE_X = 8'sd40; BASE_Y = 8'sd24; NUM_COLS = 4'd2; NUM_ROWS = 4'd2;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        n_checks++;
        if (WRITE_EN !== 1'b1 || COORD_X !== 8'sd40 || COORD_Y !== 8'sd24) begin
            n_fail++;
            $display("FAIL reset_preload: we=%b x=%0d y=%0d, required we=1 x=40 y=24",
                     WRITE_EN, COORD_X, COORD_Y);
        end
        #2;
        RST_ASYNC_N = 1'b0;
        #1;
        n_checks++;
        if ({COORD_X, COORD_Y, WRITE_EN, BUSY, DONE} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_async: x=%0d y=%0d we=%b busy=%b done=%b, required all 0",
                     COORD_X, COORD_Y, WRITE_EN, BUSY, DONE);
        end
        @(negedge CLK);
        RST_ASYNC_N = 1'b1;
        BLOCK_DONE = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK); #1;
            if (DONE || WRITE_EN || BUSY) bad++;
        end
        BLOCK_DONE = 1'b0;
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL reset_idle_after: %0d active cycles, required 0", bad);
        end
    endtask

    task automatic test_basic();
        build_expected(8'sd0, 8'sd0, 2, 2);
        run_scan(8'sd0, 8'sd0, 2, 2, 3, 0);
        n_checks++;
        if (obs_x.size() !== 4) begin
            n_fail++;
            $display("FAIL basic_count: got %0d writes, required 4", obs_x.size());
        end
        for (int i = 0; i < exp_x.size(); i++) begin
            n_checks++;
            if (i >= obs_x.size() || obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i]) begin
                n_fail++;
                if (i < obs_x.size())
                    $display("FAIL basic_coord[%0d]: got (%0d,%0d), required (%0d,%0d)",
                             i, obs_x[i], obs_y[i], exp_x[i], exp_y[i]);
                else
                    $display("FAIL basic_coord[%0d]: missing, required (%0d,%0d)",
                             i, exp_x[i], exp_y[i]);
            end
        end
        n_checks++;
        if (we_cyc.size() > 0 && we_cyc[0] !== 0) begin
            n_fail++;
            $display("FAIL basic_first_latency: first write at cycle %0d, required 0", we_cyc[0]);
        end
        for (int i = 1; i < we_cyc.size(); i++) begin
            n_checks++;
            if (we_cyc[i] - we_cyc[i-1] !== 5) begin
                n_fail++;
                $display("FAIL basic_gap[%0d]: got %0d cycles, required 5",
                         i, we_cyc[i] - we_cyc[i-1]);
            end
        end
        n_checks++;
        if (we_cyc.size() == 4 && done_cyc !== we_cyc[3] + 4) begin
            n_fail++;
            $display("FAIL basic_done_time: done at %0d, required %0d", done_cyc, we_cyc[3] + 4);
        end
        n_checks++;
        if (done_cnt !== 1 || busy_end !== 1'b0 || double_we !== 0 || timed_out) begin
            n_fail++;
            $display("FAIL basic_end: done_cnt=%0d busy=%b double_we=%0d timeout=%b, required 1/0/0/0",
                     done_cnt, busy_end, double_we, timed_out);
        end
    endtask

    task automatic test_wrap();
        run_scan(8'sd120, -8'sd4, 2, 1, 2, 0);
        n_checks++;
        if (obs_x.size() !== 2) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d writes, required 2", obs_x.size());
        end else begin
            n_checks++;
            if (obs_x[0] !== 8'sd120 || obs_y[0] !== -8'sd4) begin
                n_fail++;
                $display("FAIL wrap_first: got (%0d,%0d), required (120,-4)", obs_x[0], obs_y[0]);
            end
            n_checks++;
            if (obs_x[1] !== -8'sd128 || obs_y[1] !== -8'sd4) begin
                n_fail++;
                $display("FAIL wrap_second: got (%0d,%0d), required (-128,-4)", obs_x[1], obs_y[1]);
            end
            n_checks++;
            if (done_cyc !== we_cyc[1] + 3) begin
                n_fail++;
                $display("FAIL wrap_done_time: done at %0d, required %0d", done_cyc, we_cyc[1] + 3);
            end
        end
        n_checks++;
        if (done_cnt !== 1 || timed_out) begin
            n_fail++;
            $display("FAIL wrap_done: done_cnt=%0d timeout=%b, required 1/0", done_cnt, timed_out);
        end
    endtask

    task automatic test_zero();
        run_scan(8'sd5, 8'sd9, 0, 3, 2, 0);
        n_checks++;
        if (obs_x.size() !== 0) begin
            n_fail++;
            $display("FAIL zero_writes: got %0d writes, required 0", obs_x.size());
        end
        n_checks++;
        if (done_cnt !== 1 || done_cyc !== 0) begin
            n_fail++;
            $display("FAIL zero_done: count=%0d at cycle %0d, required 1 at 0", done_cnt, done_cyc);
        end
        n_checks++;
        if (busy_cyc !== 1 || busy_end !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_busy: busy for %0d cycles end=%b, required 1 and 0", busy_cyc, busy_end);
        end
    endtask

    task automatic test_block_done_held();
        build_expected(8'sd16, 8'sd32, 3, 2);
        run_scan(8'sd16, 8'sd32, 3, 2, -1, 1);
        n_checks++;
        if (obs_x.size() !== exp_x.size()) begin
            n_fail++;
            $display("FAIL held_count: got %0d writes, required %0d", obs_x.size(), exp_x.size());
        end
        for (int i = 0; i < exp_x.size() && i < obs_x.size(); i++) begin
            n_checks++;
            if (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i]) begin
                n_fail++;
                $display("FAIL held_coord[%0d]: got (%0d,%0d), required (%0d,%0d)",
                         i, obs_x[i], obs_y[i], exp_x[i], exp_y[i]);
            end
        end
        for (int i = 1; i < we_cyc.size(); i++) begin
            n_checks++;
            if (we_cyc[i] - we_cyc[i-1] !== 3) begin
                n_fail++;
                $display("FAIL held_gap[%0d]: got %0d cycles, required 3",
                         i, we_cyc[i] - we_cyc[i-1]);
            end
        end
        n_checks++;
        if (double_we !== 0 || done_cnt !== 1 || busy_end !== 1'b0 || timed_out) begin
            n_fail++;
            $display("FAIL held_end: double_we=%0d done_cnt=%0d busy=%b timeout=%b, required 0/1/0/0",
                     double_we, done_cnt, busy_end, timed_out);
        end
    endtask

    task automatic test_capture();
        build_expected(-8'sd10, 8'sd7, 3, 2);
        run_scan(-8'sd10, 8'sd7, 3, 2, 2, 2);
        n_checks++;
        if (obs_x.size() !== exp_x.size()) begin
            n_fail++;
            $display("FAIL capture_count: got %0d writes, required %0d", obs_x.size(), exp_x.size());
        end
        for (int i = 0; i < exp_x.size() && i < obs_x.size(); i++) begin
            n_checks++;
            if (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i]) begin
                n_fail++;
                $display("FAIL capture_coord[%0d]: got (%0d,%0d), required (%0d,%0d)",
                         i, obs_x[i], obs_y[i], exp_x[i], exp_y[i]);
            end
        end
        n_checks++;
        if (done_cnt !== 1 || timed_out) begin
            n_fail++;
            $display("FAIL capture_done: done_cnt=%0d timeout=%b, required 1/0", done_cnt, timed_out);
        end
    endtask

    task automatic test_random();
        logic signed [7:0] bx;
        logic signed [7:0] by;
        int nc;
        int nr;
        int dly;
        int errs;
        for (int t = 0; t < 10; t++) begin
            bx  = 8'($urandom);
            by  = 8'($urandom);
            nc  = int'($urandom_range(0, 5));
            nr  = int'($urandom_range(0, 4));
            dly = int'($urandom_range(1, 4));
            build_expected(bx, by, nc, nr);
            run_scan(bx, by, nc, nr, dly, 0);
            errs = 0;
            if (obs_x.size() !== exp_x.size()) errs++;
            for (int i = 0; i < exp_x.size() && i < obs_x.size(); i++) begin
                if (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i]) errs++;
            end
            for (int i = 1; i < we_cyc.size(); i++) begin
                if (we_cyc[i] - we_cyc[i-1] !== dly + 2) errs++;
            end
            n_checks++;
            if (errs !== 0 || done_cnt !== 1 || busy_end !== 1'b0 || timed_out) begin
                n_fail++;
                $display("FAIL random[%0d]: base=(%0d,%0d) grid=%0dx%0d writes=%0d/%0d errs=%0d done_cnt=%0d timeout=%b, required 0 errs, 1 done",
                         t, bx, by, nc, nr, obs_x.size(), exp_x.size(), errs, done_cnt, timed_out);
            end
        end
    endtask

    initial begin
        test_reset();
        @(posedge CLK); #1;
        test_basic();
        test_wrap();
        test_zero();
        test_block_done_held();
        test_capture();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_coord_gen
`default_nettype wire
